// File: rtl/param_counter_pkg.sv
// Shared definitions for param_counter: mode encodings and wrap-counter width.
package param_counter_pkg;

   // Run-mode field carried on the mode port
   typedef logic [1:0] mode_t;

   localparam mode_t MODE_WRAP_UP  = 2'b00;
   localparam mode_t MODE_WRAP_DN  = 2'b01;
   localparam mode_t MODE_SAT_UP   = 2'b10;
   localparam mode_t MODE_PINGPONG = 2'b11;

   // Width and ceiling of the optional terminal-count event counter
   localparam int unsigned WRAP_CNT_W = 8;
   localparam logic [WRAP_CNT_W-1:0] WRAP_CNT_MAX = {WRAP_CNT_W{1'b1}};

endpackage : param_counter_pkg

// File: rtl/param_counter.sv
// Parametrised up/down counter with wrap-up, wrap-down, saturating-up and
// ping-pong modes, synchronous load, count enable and registered tc pulse.
// Optional macro PARAM_COUNTER_WRAP_CNT_EN adds a saturating wrap_cnt output
// counting terminal-count events.
module param_counter
   import param_counter_pkg::*;
#(
   parameter int unsigned WIDTH   = 4,
   parameter int unsigned MAX_VAL = (2 ** WIDTH) - 1,
   parameter int unsigned RST_VAL = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  mode_t            mode,
   output logic [WIDTH-1:0] count,
   output logic             dir,
   output logic             tc
`ifdef PARAM_COUNTER_WRAP_CNT_EN
   ,
   output logic [WRAP_CNT_W-1:0] wrap_cnt
`endif
);

   localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);
   localparam logic [WIDTH-1:0] RST_C = WIDTH'(RST_VAL);
   localparam logic [WIDTH-1:0] ONE_C = WIDTH'(1);

   logic [WIDTH-1:0] count_nxt;
   logic             dir_nxt;
   logic             tc_nxt;

   // Next-state: load beats enable; idle cycles hold count/dir and drop tc
   always_comb begin
      count_nxt = count;
      dir_nxt   = dir;
      tc_nxt    = 1'b0;
      if (load) begin
         count_nxt = (load_val > MAX_C) ? MAX_C : load_val;
         dir_nxt   = (mode != MODE_WRAP_DN);
      end else if (en) begin
         case (mode)
            MODE_WRAP_UP: begin
               dir_nxt = 1'b1;
               if (count == MAX_C) begin
                  count_nxt = '0;
                  tc_nxt    = 1'b1;
               end else begin
                  count_nxt = count + ONE_C;
               end
            end
            MODE_WRAP_DN: begin
               dir_nxt = 1'b0;
               if (count == '0) begin
                  count_nxt = MAX_C;
                  tc_nxt    = 1'b1;
               end else begin
                  count_nxt = count - ONE_C;
               end
            end
            MODE_SAT_UP: begin
               dir_nxt = 1'b1;
               if (count != MAX_C) begin
                  count_nxt = count + ONE_C;
                  tc_nxt    = (count_nxt == MAX_C);
               end
            end
            MODE_PINGPONG: begin
               // Direction is kept from whatever mode ran before
               if (dir) begin
                  if (count == MAX_C) begin
                     count_nxt = MAX_C - ONE_C;
                     dir_nxt   = 1'b0;
                     tc_nxt    = 1'b1;
                  end else begin
                     count_nxt = count + ONE_C;
                  end
               end else begin
                  if (count == '0) begin
                     count_nxt = ONE_C;
                     dir_nxt   = 1'b1;
                     tc_nxt    = 1'b1;
                  end else begin
                     count_nxt = count - ONE_C;
                  end
               end
            end
            default: begin
               count_nxt = count;
            end
         endcase
      end
   end

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= RST_C;
         dir   <= 1'b1;
         tc    <= 1'b0;
      end else begin
         count <= count_nxt;
         dir   <= dir_nxt;
         tc    <= tc_nxt;
      end
   end

`ifdef PARAM_COUNTER_WRAP_CNT_EN
   // Saturating count of terminal-count events, cleared by load
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wrap_cnt <= '0;
      end else if (load) begin
         wrap_cnt <= '0;
      end else if (tc_nxt && (wrap_cnt != WRAP_CNT_MAX)) begin
         wrap_cnt <= wrap_cnt + WRAP_CNT_W'(1);
      end
   end
`endif

endmodule : param_counter

// File: tb/tb_param_counter.sv
// Self-checking bench for param_counter (WIDTH=4, MAX_VAL=9, RST_VAL=0).
// Covers the wrap counter when PARAM_COUNTER_WRAP_CNT_EN is defined.
module tb_param_counter;

   localparam int unsigned WIDTH = 4;
   localparam int          MAXV  = 9;
   localparam int          RSTV  = 0;

   logic             clk = 1'b0;
   logic             rst;
   logic             en;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [1:0]       mode;
   logic [WIDTH-1:0] count;
   logic             dir;
   logic             tc;
`ifdef PARAM_COUNTER_WRAP_CNT_EN
   logic [7:0]       wrap_cnt;
`endif

   int nchk  = 0;
   int npass = 0;

   // Reference model state
   int m_count;
   int m_dir;
   int m_tc;
   int m_wrap;

   param_counter #(.WIDTH(WIDTH), .MAX_VAL(MAXV), .RST_VAL(RSTV)) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .load     (load),
      .load_val (load_val),
      .mode     (mode),
      .count    (count),
      .dir      (dir),
      .tc       (tc)
`ifdef PARAM_COUNTER_WRAP_CNT_EN
      ,
      .wrap_cnt (wrap_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) begin
         npass++;
      end else begin
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag);
      chk({tag, ".count"}, 32'(count), 32'(m_count));
      chk({tag, ".dir"},   32'(dir),   32'(m_dir));
      chk({tag, ".tc"},    32'(tc),    32'(m_tc));
`ifdef PARAM_COUNTER_WRAP_CNT_EN
      chk({tag, ".wrap"},  32'(wrap_cnt), 32'(m_wrap));
`endif
   endtask

   task automatic model_reset();
      m_count = RSTV;
      m_dir   = 1;
      m_tc    = 0;
      m_wrap  = 0;
   endtask

   // One clock edge of the specified behaviour, computed arithmetically
   task automatic model_step(input logic l, input logic e, input int lv, input int md);
      m_tc = 0;
      if (l) begin
         m_count = (lv > MAXV) ? MAXV : lv;
         m_dir   = (md == 1) ? 0 : 1;
         m_wrap  = 0;
      end else if (e) begin
         case (md)
            0: begin
               m_tc    = (m_count == MAXV);
               m_count = (m_count + 1) % (MAXV + 1);
               m_dir   = 1;
            end
            1: begin
               m_tc    = (m_count == 0);
               m_count = (m_count + MAXV) % (MAXV + 1);
               m_dir   = 0;
            end
            2: begin
               m_tc    = (m_count == MAXV - 1);
               m_count = (m_count < MAXV) ? m_count + 1 : MAXV;
               m_dir   = 1;
            end
            default: begin
               // Bounce off an end wall, then move one step in the new direction
               if ((m_dir == 1 && m_count == MAXV) || (m_dir == 0 && m_count == 0)) begin
                  m_dir = 1 - m_dir;
                  m_tc  = 1;
               end
               m_count = m_count + (m_dir == 1 ? 1 : -1);
            end
         endcase
         if (m_tc == 1 && m_wrap < 255) m_wrap++;
      end
   endtask

   task automatic step(input logic l, input logic e, input int lv, input int md, input string tag);
      load     = l;
      en       = e;
      load_val = WIDTH'(lv);
      mode     = 2'(md);
      @(posedge clk);
      #1;
      model_step(l, e, lv, md);
      chk_all(tag);
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; load = 1'b0; load_val = '0; mode = 2'b00;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk_all("reset");
      rst = 1'b0;

      // Wrap-up from reset: 1..9,0,1
      for (int i = 0; i < 11; i++) begin
         step(1'b0, 1'b1, 0, 0, "wrap_up");
         if (i == 9) begin
            chk("wrap_up.zero", 32'(count), 32'd0);
            chk("wrap_up.tc",   32'(tc),    32'd1);
         end
      end

      // Wrap-down from 2: 1,0,9,8
      step(1'b1, 1'b0, 2, 1, "wrap_dn.load");
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 0, 1, "wrap_dn");

      // Saturating-up from 7: 8,9,9,9
      step(1'b1, 1'b0, 7, 2, "sat.load");
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 0, 2, "sat");
      chk("sat.hold", 32'(count), 32'd9);

      // Ping-pong from 8 up through the top turn and down through the bottom turn
      step(1'b1, 1'b0, 8, 3, "pp.load");
      for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 0, 3, "pingpong");

      // Load wins over enable and clamps above MAX_VAL
      step(1'b1, 1'b1, 15, 0, "clamp");
      chk("clamp.const", 32'(count), 32'd9);

      // Idle cycle holds
      step(1'b0, 1'b0, 3, 1, "idle");

      // Async reset between edges at count 5 while counting down
      step(1'b1, 1'b0, 6, 1, "arst.load");
      step(1'b0, 1'b1, 0, 1, "arst.step");
      chk("arst.pre", 32'(count), 32'd5);
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      chk_all("arst");
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Randomised traffic against the model
      for (int i = 0; i < 600; i++) begin
         int r;
         r = int'($urandom_range(0, 99));
         if (r < 2) begin
            #2;
            rst = 1'b1;
            #1;
            model_reset();
            chk_all("rand.rst");
            @(posedge clk);
            #1;
            rst = 1'b0;
         end else begin
            step(($urandom_range(0, 9) == 0), ($urandom_range(0, 4) != 0),
                 int'($urandom_range(0, 15)),
                 (r < 20) ? int'($urandom_range(0, 3)) : int'(mode), "rand");
         end
      end

`ifdef PARAM_COUNTER_WRAP_CNT_EN
      // 300 wraps saturate the event counter, then load clears it
      step(1'b1, 1'b0, 0, 0, "wc.load");
      for (int i = 0; i < 300 * (MAXV + 1); i++) step(1'b0, 1'b1, 0, 0, "wc");
      chk("wc.sat", 32'(wrap_cnt), 32'd255);
      step(1'b1, 1'b0, 4, 0, "wc.clear");
      chk("wc.zero", 32'(wrap_cnt), 32'd0);
`endif

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule : tb_param_counter

// File: doc/param_counter.md
Name: param_counter

Overview:
Parametrised up/down counter: the next generation of the team's fixed 4-bit free-running counter. Adds configurable width and modulus, four run modes (wrap-up, wrap-down, saturating-up, ping-pong), synchronous load, count enable and a registered terminal-count pulse. Used as a general timing/sequencing primitive in the datapath and in simulation benches that dump waveforms.

Parameters:
WIDTH, 4, counter width in bits (>= 2)
MAX_VAL, 2**WIDTH-1, top count value; counter range is 0..MAX_VAL; must satisfy 1 <= MAX_VAL <= 2**WIDTH-1
RST_VAL, 0, count value after reset; must be <= MAX_VAL

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset, asynchronous, active-high
en  input  1  count enable; one step per cycle while high
load  input  1  synchronous load strobe
load_val  input  WIDTH  value written on load
mode  input  2  00 wrap-up, 01 wrap-down, 10 saturating-up, 11 ping-pong
count  output  WIDTH  current count, registered
dir  output  1  current direction, 1 = up, registered
tc  output  1  terminal-count pulse, registered, one cycle wide

Behaviour:
- Reset (async assert, sync-clean deassert in use): count = RST_VAL, dir = 1, tc = 0.
- Priority per clock edge: rst > load > en. With en = 0 and load = 0, count and dir hold and tc = 0.
- Load: count <= min(load_val, MAX_VAL) (values above MAX_VAL clamp), tc <= 0, dir <= 1 (except mode 01: dir <= 0).
- tc reflects the step taken on the previous edge; it is never high two cycles in a row unless two consecutive steps each qualify.
- Mode 00, wrap-up: count < MAX_VAL -> count+1. count == MAX_VAL -> 0 with tc = 1. dir = 1.
- Mode 01, wrap-down: count > 0 -> count-1. count == 0 -> MAX_VAL with tc = 1. dir = 0.
- Mode 10, saturating-up: count < MAX_VAL -> count+1. tc = 1 only on the step that lands on MAX_VAL. At MAX_VAL, further enables hold with tc = 0. dir = 1.
- Mode 11, ping-pong:
  - dir = 1 and count < MAX_VAL -> count+1.
  - dir = 1 and count == MAX_VAL -> count = MAX_VAL-1, dir = 0, tc = 1.
  - dir = 0 and count > 0 -> count-1.
  - dir = 0 and count == 0 -> count = 1, dir = 1, tc = 1.
- Mode change takes effect on the next enabled step. Entering mode 11 keeps the current dir. Entering 00/10 forces dir = 1 on the next enabled step; entering 01 forces dir = 0.
- All arithmetic is WIDTH bits; no intermediate overflow is possible because count never exceeds MAX_VAL.
- Reset mid-sequence discards all state immediately, with no clock required.

Optional Feature:
PARAM_COUNTER_WRAP_CNT_EN
- Defined: adds output wrap_cnt [7:0], registered. It increments on every edge where tc is being set to 1 and saturates at 255. Reset and load clear it to 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package param_counter_pkg holds the mode encodings MODE_WRAP_UP = 2'b00, MODE_WRAP_DN = 2'b01, MODE_SAT_UP = 2'b10, MODE_PINGPONG = 2'b11, plus a typedef for the 2-bit mode field.
- No sub-module: the next-state logic is a single combinational block feeding one registered block.

Test Plan:
- WIDTH=4, MAX_VAL=9, mode 00, en=1 from reset for 12 cycles -> count 0,1..9,0,1; tc high exactly in the cycle count shows 0 after 9.
- Mode 01, load_val=2 then en=1 -> count 2,1,0,9,8; tc high with the first 9; dir=0.
- Mode 10 from 7 -> count 8,9,9,9; tc high only with the first 9.
- Mode 11 from 8 -> count 9,8,7; dir 1->0 alongside 8 after 9; then from 1 -> 0,1 with dir 0->1; tc on each turnaround.
- load and en both high with load_val=15, MAX_VAL=9 -> count=9, tc=0. Assert rst asynchronously mid-count at count=5 -> count=RST_VAL before the next edge, dir=1.
- With PARAM_COUNTER_WRAP_CNT_EN, mode 00 running 300 wraps -> wrap_cnt saturates at 255; a load clears it to 0.
